// File: rtl/axi_node_pkg.sv
// Shared AXI node definitions: beat-length width, W-allocator state
// encoding, and the one-hot AND-OR mux used to select initiator slices.
package axi_node_pkg;

  localparam int AXI_LEN_W     = 8;
  // Widest initiator count the column mux below can handle.
  localparam int MUX_MAX_PORTS = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    MID   = 2'd2
  } w_alloc_state_e;

  // One output bit of a one-hot AND-OR mux: col holds the same bit position
  // of every initiator's slice, sel is the one-hot (or all-zero) select.
  function automatic logic onehot_mux(input logic [MUX_MAX_PORTS-1:0] sel,
                                      input logic [MUX_MAX_PORTS-1:0] col);
    return |(sel & col);
  endfunction

endpackage

// File: rtl/fifo_v2.sv
// Common synchronous FIFO. Power-of-two depth, optional fall-through.
// With FALL_THROUGH=0 a pushed word is visible on data_o the next cycle.
module fifo_v2 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  localparam int unsigned ADDR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_W:0]       usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr, rd_ptr;
  logic [ADDR_W:0]       cnt;
  logic                  bypass, push_eff, pop_eff;
  logic                  unused_testmode;

  // No scan-specific behaviour in this FIFO; the pin is kept for interface
  // compatibility with the other node blocks.
  assign unused_testmode = testmode_i;

  assign full_o   = (cnt == (ADDR_W+1)'(DEPTH));
  assign usage_o  = cnt;
  // A fall-through FIFO that is empty passes a simultaneous push straight out.
  assign bypass   = FALL_THROUGH && (cnt == '0) && push_i && pop_i;
  assign push_eff = push_i && !full_o && !bypass;
  assign pop_eff  = pop_i && (cnt != '0);
  assign empty_o  = (cnt == '0) && !(FALL_THROUGH && push_i);
  assign data_o   = (FALL_THROUGH && (cnt == '0)) ? data_i : mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + 1'b1;
      if (pop_eff)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_eff, pop_eff})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_eff) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/axi_w_allocator.sv
// Per-target W-channel scheduler. Serves initiators in AW grant order,
// holding the mux on the head source until the burst's last beat, and
// generating wlast from the recorded awlen.
//
// state | meaning
// IDLE  | no granted AW waiting for data
// BURST | head burst valid, no beat accepted yet (beat_cnt == 0)
// MID   | head burst partially transferred (beat_cnt > 0)
module axi_w_allocator
  import axi_node_pkg::*;
#(
  parameter int N_INIT_PORT = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int AXI_DATA_W  = 64,
  parameter int AXI_USER_W  = 6,
  parameter int AXI_STRB_W  = AXI_DATA_W/8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              test_en_i,
  input  logic                              push_ID_i,
  input  logic [N_INIT_PORT-1:0]            ID_i,
  input  logic [AXI_LEN_W-1:0]              awlen_i,
  output logic                              grant_FIFO_ID_o,
  input  logic [N_INIT_PORT-1:0]            wvalid_i,
  input  logic [N_INIT_PORT*AXI_DATA_W-1:0] wdata_i,
  input  logic [N_INIT_PORT*AXI_STRB_W-1:0] wstrb_i,
  input  logic [N_INIT_PORT*AXI_USER_W-1:0] wuser_i,
  input  logic [N_INIT_PORT-1:0]            wlast_i,
  output logic [N_INIT_PORT-1:0]            wready_o,
  output logic                              wvalid_o,
  output logic [AXI_DATA_W-1:0]             wdata_o,
  output logic [AXI_STRB_W-1:0]             wstrb_o,
  output logic [AXI_USER_W-1:0]             wuser_o,
  output logic                              wlast_o,
  input  logic                              wready_i,
  output logic                              wlast_err_o
);

  localparam int ENTRY_W = N_INIT_PORT + AXI_LEN_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  logic                     fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CNT_W-1:0]         fifo_usage;
  logic [ENTRY_W-1:0]       fifo_head;
  logic                     head_valid, head_valid_nxt;
  logic [N_INIT_PORT-1:0]   sel;
  logic [AXI_LEN_W-1:0]     head_len;
  logic                     hs, sel_wlast;
  logic [AXI_LEN_W-1:0]     beat_cnt, beat_cnt_nxt;
  logic [MUX_MAX_PORTS-1:0] sel_wide, col;
  w_alloc_state_e           state;

  assign grant_FIFO_ID_o = ~fifo_full;
  assign fifo_push       = push_ID_i & ~fifo_full;

  fifo_v2 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (ENTRY_W),
    .DEPTH        (FIFO_DEPTH)
  ) u_id_fifo (
    .clk_i      (clk),
    .rst_ni     (~rst),
    .flush_i    (1'b0),
    .testmode_i (test_en_i),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .usage_o    (fifo_usage),
    .data_i     ({ID_i, awlen_i}),
    .push_i     (fifo_push),
    .data_o     (fifo_head),
    .pop_i      (fifo_pop)
  );

  // Head decode: an empty FIFO forces an all-zero select, which zeroes
  // every muxed output without extra gating.
  assign head_valid = ~fifo_empty;
  assign sel        = head_valid ? fifo_head[ENTRY_W-1:AXI_LEN_W] : '0;
  assign head_len   = fifo_head[AXI_LEN_W-1:0];
  assign sel_wide   = MUX_MAX_PORTS'(sel);

  assign wvalid_o  = |(wvalid_i & sel);
  assign wready_o  = sel & {N_INIT_PORT{wready_i}};
  assign sel_wlast = |(wlast_i & sel);
  assign wlast_o   = head_valid & (beat_cnt == head_len);
  assign hs        = wvalid_o & wready_i;
  assign fifo_pop  = hs & wlast_o;

  // Next-cycle bookkeeping for the beat counter and the state register.
  assign beat_cnt_nxt   = hs ? (wlast_o ? '0 : beat_cnt + 1'b1) : beat_cnt;
  assign head_valid_nxt = fifo_push |
                          (head_valid & ~(fifo_pop & (fifo_usage == CNT_W'(1))));

  // Column-wise AND-OR mux of data, strobe and user slices.
  always_comb begin
    col     = '0;
    wdata_o = '0;
    wstrb_o = '0;
    wuser_o = '0;
    for (int b = 0; b < AXI_DATA_W; b++) begin
      col = '0;
      for (int i = 0; i < N_INIT_PORT; i++) col[i] = wdata_i[i*AXI_DATA_W + b];
      wdata_o[b] = onehot_mux(sel_wide, col);
    end
    for (int b = 0; b < AXI_STRB_W; b++) begin
      col = '0;
      for (int i = 0; i < N_INIT_PORT; i++) col[i] = wstrb_i[i*AXI_STRB_W + b];
      wstrb_o[b] = onehot_mux(sel_wide, col);
    end
    for (int b = 0; b < AXI_USER_W; b++) begin
      col = '0;
      for (int i = 0; i < N_INIT_PORT; i++) col[i] = wuser_i[i*AXI_USER_W + b];
      wuser_o[b] = onehot_mux(sel_wide, col);
    end
  end

  // Burst sequencer: beat counter, state and registered wlast mismatch flag.
  // Sequencing follows awlen only; a wrong wlast_i is reported, never obeyed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt    <= '0;
      state       <= IDLE;
      wlast_err_o <= 1'b0;
    end else begin
      beat_cnt    <= beat_cnt_nxt;
      wlast_err_o <= hs & (sel_wlast ^ wlast_o);
      if (!head_valid_nxt)          state <= IDLE;
      else if (beat_cnt_nxt == '0)  state <= BURST;
      else                          state <= MID;
    end
  end

  // Interface and internal consistency checks.
  a_onehot_id: assert property (@(posedge clk) disable iff (rst)
    push_ID_i |-> $onehot(ID_i));
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    fifo_push |-> !fifo_full);
  a_idle_empty: assert property (@(posedge clk) disable iff (rst)
    (state == IDLE) == fifo_empty);
  a_mid_cnt: assert property (@(posedge clk) disable iff (rst)
    (state == MID) == (beat_cnt != '0));

endmodule
